// File: rtl/regf_writeback_arbiter.sv
// Round-robin writeback arbiter: grants up to SS of FU_COUNT results per cycle onto registered CDB write ports.
// Optional arbitration-loss counter enabled by REGF_WB_ARB_STATS_EN.
module regf_writeback_arbiter #(
  parameter int SS       = 2,
  parameter int FU_COUNT = 4,
  parameter int DATA_W   = 32,
  parameter int PREG_W   = 6,
  parameter int ROB_W    = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [FU_COUNT-1:0]               fu_valid,
  output logic [FU_COUNT-1:0]               fu_ready,
  input  logic [FU_COUNT-1:0][PREG_W-1:0]   fu_preg,
  input  logic [FU_COUNT-1:0][DATA_W-1:0]   fu_value,
  input  logic [FU_COUNT-1:0][ROB_W-1:0]    fu_rob_id,
  output logic [SS-1:0]                     wb_valid,
  output logic [SS-1:0][PREG_W-1:0]         wb_preg,
  output logic [SS-1:0][DATA_W-1:0]         wb_value,
  output logic [SS-1:0][ROB_W-1:0]          wb_rob_id,
  output logic [31:0]                       stall_count
);

  localparam int PTR_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
  localparam int CNT_W = $clog2(SS + 1);

  logic [PTR_W-1:0]          rr_ptr_r;
  logic [PTR_W-1:0]          scan_idx_s;
  logic [PTR_W-1:0]          next_ptr_s;
  logic [CNT_W-1:0]          ngrant_s;
  logic                      take_s;
  logic [FU_COUNT-1:0]       grant_s;
  logic [SS-1:0]             slot_used_s;
  logic [SS-1:0][PTR_W-1:0]  slot_idx_s;

  // Scan from rr_ptr, granting the first SS valid FUs; the k-th grant lands in slot k
  always_comb begin
    grant_s     = '0;
    slot_used_s = '0;
    slot_idx_s  = '0;
    ngrant_s    = '0;
    take_s      = 1'b0;
    next_ptr_s  = rr_ptr_r;
    scan_idx_s  = rr_ptr_r;
    for (int k = 0; k < FU_COUNT; k++) begin
      take_s = fu_valid[scan_idx_s] && (ngrant_s < CNT_W'(SS)) && !flush && !rst;
      grant_s[scan_idx_s] = grant_s[scan_idx_s] | take_s;
      for (int s = 0; s < SS; s++) begin
        if (take_s && (ngrant_s == CNT_W'(s))) begin
          slot_used_s[s] = 1'b1;
          slot_idx_s[s]  = scan_idx_s;
        end else begin
          slot_used_s[s] = slot_used_s[s];
        end
      end
      if (take_s) begin
        ngrant_s   = ngrant_s + CNT_W'(1);
        next_ptr_s = (scan_idx_s == PTR_W'(FU_COUNT - 1)) ? '0 : scan_idx_s + PTR_W'(1);
      end else begin
        ngrant_s   = ngrant_s;
      end
      scan_idx_s = (scan_idx_s == PTR_W'(FU_COUNT - 1)) ? '0 : scan_idx_s + PTR_W'(1);
    end
  end

  assign fu_ready = grant_s;

  // Write-port registers and round-robin pointer; x0 results take a slot but never assert wb_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r  <= '0;
      wb_valid  <= '0;
      wb_preg   <= '0;
      wb_value  <= '0;
      wb_rob_id <= '0;
    end else if (flush) begin
      wb_valid  <= '0;
    end else begin
      for (int s = 0; s < SS; s++) begin
        wb_valid[s] <= slot_used_s[s] && (fu_preg[slot_idx_s[s]] != PREG_W'(0));
        if (slot_used_s[s]) begin
          wb_preg[s]   <= fu_preg[slot_idx_s[s]];
          wb_value[s]  <= fu_value[slot_idx_s[s]];
          wb_rob_id[s] <= fu_rob_id[slot_idx_s[s]];
        end
      end
      if (|grant_s) begin
        rr_ptr_r <= next_ptr_s;
      end
    end
  end

`ifdef REGF_WB_ARB_STATS_EN
  localparam int LOST_W = $clog2(FU_COUNT + 1);

  logic [31:0]       stall_r;
  logic [LOST_W-1:0] lost_s;
  logic [32:0]       stall_sum_s;

  // Count requesters that were valid but not granted this cycle
  always_comb begin
    lost_s = '0;
    for (int i = 0; i < FU_COUNT; i++) begin
      lost_s = lost_s + LOST_W'(fu_valid[i] & ~grant_s[i]);
    end
    stall_sum_s = {1'b0, stall_r} + 33'(lost_s);
  end

  // Saturating arbitration-loss counter
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r <= 32'd0;
    end else begin
      stall_r <= stall_sum_s[32] ? 32'hFFFF_FFFF : stall_sum_s[31:0];
    end
  end

  assign stall_count = stall_r;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_regf_writeback_arbiter.sv
// Self-checking bench for regf_writeback_arbiter: directed scenarios plus randomized traffic against a scan-order model.
module tb_regf_writeback_arbiter;

  localparam int SS = 2;
  localparam int FU = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic [FU-1:0]          fu_valid;
  logic [FU-1:0]          fu_ready;
  logic [FU-1:0][5:0]     fu_preg;
  logic [FU-1:0][31:0]    fu_value;
  logic [FU-1:0][2:0]     fu_rob_id;
  logic [SS-1:0]          wb_valid;
  logic [SS-1:0][5:0]     wb_preg;
  logic [SS-1:0][31:0]    wb_value;
  logic [SS-1:0][2:0]     wb_rob_id;
  logic [31:0]            stall_count;

  int checks = 0;
  int failures = 0;

  // reference model state
  int                  m_ptr;
  logic [FU-1:0]       m_rdy;
  int                  m_slot [SS];
  int                  m_n;
  logic [SS-1:0]       m_wbv;
  logic [SS-1:0][5:0]  m_preg;
  logic [SS-1:0][31:0] m_val;
  logic [SS-1:0][2:0]  m_rob;
  logic [SS-1:0]       m_dc;
  longint              m_stall;

  regf_writeback_arbiter #(.SS(SS), .FU_COUNT(FU), .DATA_W(32), .PREG_W(6), .ROB_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_preg(fu_preg),
    .fu_value(fu_value), .fu_rob_id(fu_rob_id),
    .wb_valid(wb_valid), .wb_preg(wb_preg), .wb_value(wb_value),
    .wb_rob_id(wb_rob_id), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_stall();
`ifdef REGF_WB_ARB_STATS_EN
    return m_stall[31:0];
`else
    return 32'd0;
`endif
  endfunction

  // grant set: walk ptr, ptr+1, ... mod FU and take the first SS valid requesters
  task automatic compute();
    m_rdy = '0;
    m_n = 0;
    if (!flush && !rst) begin
      for (int k = 0; k < FU; k++) begin
        int idx;
        idx = (m_ptr + k) % FU;
        if (fu_valid[idx] && m_n < SS) begin
          m_rdy[idx] = 1'b1;
          m_slot[m_n] = idx;
          m_n++;
        end
      end
    end
  endtask

  // advance model by one clock with current inputs, then move to 1 time unit after the edge
  task automatic step();
    compute();
    if (rst) begin
      m_stall = 0; m_ptr = 0; m_wbv = '0; m_preg = '0; m_val = '0; m_rob = '0; m_dc = '0;
    end else begin
      m_stall += $countones(fu_valid & ~m_rdy);
      if (m_stall > 64'hFFFF_FFFF) m_stall = 64'hFFFF_FFFF;
      if (flush) begin
        m_wbv = '0;
      end else begin
        for (int s = 0; s < SS; s++) begin
          if (s < m_n) begin
            m_wbv[s]  = (fu_preg[m_slot[s]] != 6'd0);
            m_dc[s]   = (fu_preg[m_slot[s]] == 6'd0);
            m_preg[s] = fu_preg[m_slot[s]];
            m_val[s]  = fu_value[m_slot[s]];
            m_rob[s]  = fu_rob_id[m_slot[s]];
          end else begin
            m_wbv[s] = 1'b0;
          end
        end
        if (m_n > 0) m_ptr = (m_slot[m_n-1] + 1) % FU;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; fu_valid = '0;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pay(int i, int g);
    return 32'hC0DE_0000 + 32'(i << 8) + 32'(g);
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; fu_valid = 4'hF;
    fu_preg = {6'd4, 6'd3, 6'd2, 6'd1};
    #1;
    checks++;
    if (fu_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_ready got=%b want=0000", fu_ready);
    end
    step();
    checks++;
    if (wb_valid !== 2'b00 || wb_preg !== '0 || wb_value !== '0 || wb_rob_id !== '0 || stall_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_state got v=%b p=%h d=%h r=%h s=%0d want all zero", wb_valid, wb_preg, wb_value, wb_rob_id, stall_count);
    end
    rst = 1'b0; fu_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    fu_valid = 4'b0100; fu_preg[2] = 6'd5; fu_value[2] = 32'hDEAD_BEEF; fu_rob_id[2] = 3'd3;
    #1;
    checks++;
    if (fu_ready !== 4'b0100) begin
      failures++; $display("FAIL single_ready got=%b want=0100", fu_ready);
    end
    step();
    fu_valid = '0;
    checks++;
    if (wb_valid !== 2'b01 || wb_preg[0] !== 6'd5 || wb_value[0] !== 32'hDEAD_BEEF || wb_rob_id[0] !== 3'd3) begin
      failures++;
      $display("FAIL single_wb got v=%b p=%0d d=%h r=%0d want v=01 p=5 d=deadbeef r=3", wb_valid, wb_preg[0], wb_value[0], wb_rob_id[0]);
    end
    // pointer now 3: all valid must grant FU3 then FU0
    fu_valid = 4'hF;
    for (int i = 0; i < FU; i++) begin
      fu_preg[i] = 6'(i + 8); fu_value[i] = pay(i, 9); fu_rob_id[i] = 3'(i);
    end
    #1;
    checks++;
    if (fu_ready !== 4'b1001) begin
      failures++; $display("FAIL single_ptr3 got=%b want=1001", fu_ready);
    end
    step();
    fu_valid = '0;
    checks++;
    if (wb_valid !== 2'b11 || wb_preg[0] !== 6'd11 || wb_preg[1] !== 6'd8 || wb_value[0] !== pay(3, 9)) begin
      failures++; $display("FAIL single_ptr3_wb got v=%b p0=%0d p1=%0d want v=11 p0=11 p1=8", wb_valid, wb_preg[0], wb_preg[1]);
    end
  endtask

  task automatic test_all_four();
    int gen [FU];
    logic [FU-1:0] exp_rdy;
    int s0;
    do_reset();
    for (int i = 0; i < FU; i++) gen[i] = 0;
    fu_valid = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < FU; i++) begin
        fu_preg[i] = 6'(i + 20); fu_value[i] = pay(i, gen[i]); fu_rob_id[i] = 3'(i + c);
      end
      exp_rdy = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      s0 = (c % 2 == 0) ? 0 : 2;
      #1;
      checks++;
      if (fu_ready !== exp_rdy) begin
        failures++; $display("FAIL all4_ready c=%0d got=%b want=%b", c, fu_ready, exp_rdy);
      end
      step();
      checks++;
      if (wb_valid !== 2'b11 || wb_value[0] !== pay(s0, gen[s0]) || wb_value[1] !== pay(s0 + 1, gen[s0 + 1]) ||
          wb_preg[0] !== 6'(s0 + 20) || wb_preg[1] !== 6'(s0 + 21)) begin
        failures++;
        $display("FAIL all4_wb c=%0d got v=%b d0=%h d1=%h want v=11 d0=%h d1=%h", c, wb_valid, wb_value[0], wb_value[1],
                 pay(s0, gen[s0]), pay(s0 + 1, gen[s0 + 1]));
      end
      gen[s0]++; gen[s0 + 1]++;
    end
    fu_valid = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    fu_valid = 4'b0100; fu_preg[2] = 6'd1;
    #1;
    step();
    for (int i = 0; i < FU; i++) begin
      fu_preg[i] = 6'(i + 40); fu_value[i] = pay(i, 40); fu_rob_id[i] = 3'(7 - i);
    end
    fu_valid = 4'b1011;
    #1;
    checks++;
    if (fu_ready !== 4'b1001) begin
      failures++; $display("FAIL wrap_ready got=%b want=1001", fu_ready);
    end
    step();
    fu_valid = 4'b0010;
    checks++;
    if (wb_valid !== 2'b11 || wb_preg[0] !== 6'd43 || wb_preg[1] !== 6'd40 || wb_rob_id[0] !== 3'd4) begin
      failures++; $display("FAIL wrap_wb got v=%b p0=%0d p1=%0d want v=11 p0=43 p1=40", wb_valid, wb_preg[0], wb_preg[1]);
    end
    #1;
    checks++;
    if (fu_ready !== 4'b0010) begin
      failures++; $display("FAIL wrap_next_ready got=%b want=0010", fu_ready);
    end
    step();
    fu_valid = '0;
    checks++;
    if (wb_valid !== 2'b01 || wb_preg[0] !== 6'd41 || wb_value[0] !== pay(1, 40)) begin
      failures++; $display("FAIL wrap_next_wb got v=%b p0=%0d want v=01 p0=41", wb_valid, wb_preg[0]);
    end
  endtask

  task automatic test_x0();
    do_reset();
    fu_valid = 4'b0011; fu_preg[0] = 6'd0; fu_preg[1] = 6'd7; fu_value[1] = 32'h1234_5678;
    #1;
    checks++;
    if (fu_ready !== 4'b0011) begin
      failures++; $display("FAIL x0_ready got=%b want=0011", fu_ready);
    end
    step();
    fu_valid = '0;
    checks++;
    if (wb_valid !== 2'b10 || wb_preg[1] !== 6'd7 || wb_value[1] !== 32'h1234_5678) begin
      failures++; $display("FAIL x0_wb got v=%b p1=%0d want v=10 p1=7", wb_valid, wb_preg[1]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    fu_valid = 4'b0010; fu_preg[1] = 6'd9; fu_value[1] = 32'hF00D_0001; fu_rob_id[1] = 3'd5;
    #1;
    checks++;
    if (fu_ready !== 4'b0010) begin
      failures++; $display("FAIL flush_accept got=%b want=0010", fu_ready);
    end
    step();
    fu_valid = 4'b0101; flush = 1'b1; fu_preg[0] = 6'd3; fu_preg[2] = 6'd4;
    #1;
    checks++;
    if (fu_ready !== 4'b0000 || wb_valid !== 2'b01 || wb_preg[0] !== 6'd9 || wb_rob_id[0] !== 3'd5) begin
      failures++; $display("FAIL flush_cycle got rdy=%b v=%b p0=%0d want rdy=0000 v=01 p0=9", fu_ready, wb_valid, wb_preg[0]);
    end
    step();
    flush = 1'b0;
    checks++;
    if (wb_valid !== 2'b00) begin
      failures++; $display("FAIL flush_kill got v=%b want=00", wb_valid);
    end
    fu_valid = 4'hF; fu_preg = {6'd13, 6'd12, 6'd11, 6'd10};
    #1;
    checks++;
    if (fu_ready !== 4'b1100) begin
      failures++; $display("FAIL flush_ptr got=%b want=1100", fu_ready);
    end
    step();
    fu_valid = '0;
  endtask

  task automatic test_stats();
    do_reset();
    fu_valid = 4'hF; fu_preg = {6'd4, 6'd3, 6'd2, 6'd1};
    for (int c = 0; c < 3; c++) begin
      #1;
      step();
    end
    fu_valid = '0;
    checks++;
`ifdef REGF_WB_ARB_STATS_EN
    if (stall_count !== 32'd6) begin
      failures++; $display("FAIL stats_count got=%0d want=6", stall_count);
    end
`else
    if (stall_count !== 32'd0) begin
      failures++; $display("FAIL stats_tied got=%0d want=0", stall_count);
    end
`endif
    do_reset();
    checks++;
    if (stall_count !== 32'd0) begin
      failures++; $display("FAIL stats_reset got=%0d want=0", stall_count);
    end
  endtask

  task automatic test_random();
    logic [FU-1:0] acc;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < FU; i++) begin
        if (!fu_valid[i] && $urandom_range(1, 0) == 1) begin
          fu_valid[i]  = 1'b1;
          fu_preg[i]   = ($urandom_range(7, 0) == 0) ? 6'd0 : 6'($urandom_range(63, 1));
          fu_value[i]  = $urandom;
          fu_rob_id[i] = 3'($urandom_range(7, 0));
        end
      end
      flush = ($urandom_range(15, 0) == 0);
      rst   = ($urandom_range(99, 0) == 0);
      #1;
      compute();
      acc = m_rdy;
      checks++;
      if (fu_ready !== m_rdy) begin
        failures++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, fu_ready, m_rdy);
      end
      step();
      checks++;
      if (wb_valid !== m_wbv) begin
        failures++; $display("FAIL rand_wb_valid c=%0d got=%b want=%b", c, wb_valid, m_wbv);
      end
      for (int s = 0; s < SS; s++) begin
        if (!m_dc[s]) begin
          checks++;
          if (wb_preg[s] !== m_preg[s] || wb_value[s] !== m_val[s] || wb_rob_id[s] !== m_rob[s]) begin
            failures++;
            $display("FAIL rand_payload c=%0d s=%0d got p=%0d d=%h r=%0d want p=%0d d=%h r=%0d", c, s,
                     wb_preg[s], wb_value[s], wb_rob_id[s], m_preg[s], m_val[s], m_rob[s]);
          end
        end
      end
      checks++;
      if (stall_count !== exp_stall()) begin
        failures++; $display("FAIL rand_stall c=%0d got=%0d want=%0d", c, stall_count, exp_stall());
      end
      fu_valid = fu_valid & ~acc;
    end
    rst = 1'b0; flush = 1'b0; fu_valid = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; fu_valid = '0;
    fu_preg = '0; fu_value = '0; fu_rob_id = '0;
    m_ptr = 0; m_rdy = '0; m_n = 0; m_wbv = '0; m_preg = '0; m_val = '0; m_rob = '0; m_dc = '0; m_stall = 0;
    m_slot[0] = 0; m_slot[1] = 0;
    test_reset();
    test_single();
    test_all_four();
    test_wrap();
    test_x0();
    test_flush();
    test_stats();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regf_writeback_arbiter.md
Name: regf_writeback_arbiter

Overview:
- Schedules functional-unit results onto the SS write ports of the physical register file (the CDB).
- Up to FU_COUNT requesters compete each cycle; a round-robin scheduler grants at most SS of them.
- Granted results are registered and driven on the write ports one cycle later, together with the ROB id used for wakeup.
- Sits between the FU output stages and the physical register file, ROB and reservation stations.

Parameters:
- SS, 2, number of write ports (grants per cycle).
- FU_COUNT, 4, number of requesting functional units.
- DATA_W, 32, register value width.
- PREG_W, 6, physical register index width (64 entries).
- ROB_W, 3, ROB id width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush; kills all in-flight and newly presented results.
- fu_valid  in  FU_COUNT  per-FU result valid.
- fu_ready  out  FU_COUNT  per-FU grant; the FU's result is accepted this cycle.
- fu_preg  in  FU_COUNT x PREG_W  destination physical register per FU.
- fu_value  in  FU_COUNT x DATA_W  result value per FU.
- fu_rob_id  in  FU_COUNT x ROB_W  ROB id per FU.
- wb_valid  out  SS  write-port valid (registered).
- wb_preg  out  SS x PREG_W  write-port destination (registered).
- wb_value  out  SS x DATA_W  write-port value (registered).
- wb_rob_id  out  SS x ROB_W  write-port ROB id (registered).
- stall_count  out  32  arbitration-loss counter (see Optional Feature).

Behaviour:
- Reset (rst high at a clk edge):
  - rr_ptr, wb_valid, wb_preg, wb_value, wb_rob_id and stall_count all go to 0.
  - fu_ready is 0 while rst is high.
- Handshake:
  - Transfer occurs when fu_valid[i] and fu_ready[i] are both high.
  - fu_ready is combinational from fu_valid, rr_ptr and flush only; it never depends on fu_preg, fu_value or fu_rob_id.
  - An FU holds valid and its payload stable until accepted.
- Grant:
  - Scan indices rr_ptr, rr_ptr+1, … mod FU_COUNT.
  - The first SS indices with fu_valid high are granted.
  - The k-th grant in scan order (k = 0..SS-1) maps to output slot k.
- Latency: a result accepted in cycle N appears on wb_* in cycle N+1, in its slot, with wb_valid high.
- Unused slots: wb_valid = 0; wb_preg, wb_value and wb_rob_id hold their previous values.
- Pointer update:
  - If any grant occurred: rr_ptr <= (index of the last granted FU + 1) mod FU_COUNT.
  - Otherwise rr_ptr is unchanged.
  - Wrap from FU_COUNT-1 to 0.
- Fairness: a continuously valid FU is granted within ceil(FU_COUNT/SS) cycles.
- Physical register 0 (fu_preg == 0):
  - The request is still granted and consumes a slot.
  - Its slot drives wb_valid = 0, so x0 is never written.
- Flush:
  - While flush is high, fu_ready = 0.
  - The next edge forces wb_valid = 0 and leaves rr_ptr unchanged.
  - Results registered in the flush cycle are discarded.
- Flush and rst high together: rst wins.
- Reset mid-operation: in-flight wb entries are dropped and FUs see no acceptance.
- No result is ever duplicated or dropped except by flush or rst.

Optional Feature:
- Macro: REGF_WB_ARB_STATS_EN.
- Defined:
  - stall_count increments by the number of FUs with fu_valid high and fu_ready low in that cycle, counting flush cycles.
  - It saturates at 2^32-1 and is cleared by rst.
- Undefined: stall_count is tied to 0 and no counter logic is generated.

Test Plan:
- Single request: FU_COUNT=4, SS=2, only FU2 valid with preg=5, value=0xDEADBEEF, rob=3.
  - Same cycle: fu_ready=0100.
  - Next cycle: slot0 wb_valid=1, preg=5, value=0xDEADBEEF, rob=3; slot1 wb_valid=0.
  - rr_ptr becomes 3.
- All four FUs valid for 4 cycles starting from rr_ptr=0.
  - Grants are {0,1}, {2,3}, {0,1}, {2,3}.
  - Each FU's payload appears once per grant, in slot order.
- Wrap-around: rr_ptr=3, FU0, FU1 and FU3 valid.
  - FU3 is granted to slot0 and FU0 to slot1; FU1 is stalled.
  - rr_ptr becomes 1; the next cycle grants FU1.
- x0 suppression: FU0 has preg=0 and FU1 has preg=7, both valid.
  - Both receive fu_ready.
  - Next cycle: slot0 wb_valid=0; slot1 wb_valid=1 with preg=7.
- Flush: FU1 is accepted in cycle N and flush is high in cycle N+1.
  - FU1's result appears in N+1.
  - fu_ready=0000 during N+1.
  - wb_valid=00 at N+2.
  - rr_ptr is unchanged across the flush.
- Stats (REGF_WB_ARB_STATS_EN): 4 FUs held valid for 3 cycles with SS=2 gives stall_count=6; rst returns it to 0.
